// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush sequencer for the 5-stage miniRV pipeline
// Inputs : clk, rst_n (async, active-low), ID source regs/use flags, EX dest/write/wd_sel,
//          ex_redirect, mem_access, perf_clr
// Outputs: per-register stall/flush controls (Mealy), stall_cycles/flush_events
//          saturating counters, busy while a DRAM access is in flight
module pipe_hazard_ctrl #(
    parameter int         MEM_LAT  = 2,
    parameter logic [1:0] LOAD_SEL = 2'b01,
    parameter int         CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic [4:0]       ex_wR,
    input  logic             ex_rf_we,
    input  logic [1:0]       ex_wd_sel,
    input  logic             ex_redirect,
    input  logic             mem_access,
    input  logic             perf_clr,
    output logic             pc_stall,
    output logic             if_id_stall,
    output logic             id_ex_stall,
    output logic             ex_mem_stall,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             mem_wb_flush,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events,
    output logic             busy
);
    localparam int WW = $clog2(MEM_LAT) + 1;
    typedef enum logic [1:0] {RUN, MEM_WAIT, MEM_DONE} state_t;
    state_t        state;
    logic [WW-1:0] wcnt;
    logic          lu_hazard, mem_trig, freeze, redir, lu;
    // Every control is gated by rst_n so the pipeline sees no stall/flush while held in reset.
    always_comb begin
        lu_hazard = ex_rf_we && (ex_wd_sel == LOAD_SEL) && (ex_wR != 5'd0) &&
                    ((id_rs1_used && id_rs1 == ex_wR) || (id_rs2_used && id_rs2 == ex_wR));
        mem_trig  = rst_n && (state == RUN) && mem_access && (MEM_LAT > 1);
        freeze    = mem_trig || (rst_n && state == MEM_WAIT);
        redir     = rst_n && !freeze && ex_redirect;
        lu        = rst_n && !freeze && !ex_redirect && lu_hazard;
    end
    assign pc_stall     = freeze || lu;
    assign if_id_stall  = freeze || lu;
    assign id_ex_stall  = freeze;
    assign ex_mem_stall = freeze;
    assign mem_wb_flush = freeze;
    assign if_id_flush  = redir;
    assign id_ex_flush  = redir || lu;
    assign busy         = rst_n && (state != RUN);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= RUN;
            wcnt         <= '0;
            stall_cycles <= '0;
            flush_events <= '0;
        end else begin
            // wcnt holds the remaining MEM_WAIT cycles; MEM_DONE is the completing cycle.
            if (mem_trig) begin
                wcnt  <= WW'(MEM_LAT - 2);
                state <= (MEM_LAT == 2) ? MEM_DONE : MEM_WAIT;
            end else if (state == MEM_WAIT) begin
                if (wcnt == WW'(1)) state <= MEM_DONE;
                else wcnt <= wcnt - 1'b1;
            end else if (state == MEM_DONE) begin
                state <= RUN;
            end
            stall_cycles <= perf_clr ? '0 : (pc_stall && stall_cycles != '1) ? stall_cycles + 1'b1 : stall_cycles;
            flush_events <= perf_clr ? '0 : (redir && flush_events != '1) ? flush_events + 1'b1 : flush_events;
        end
    end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: scoreboard bench over three parameterisations of pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;
    logic       clk = 1'b0, rst_n = 1'b0;
    logic [4:0] id_rs1, id_rs2, ex_wR;
    logic       id_rs1_used, id_rs2_used, ex_rf_we, ex_redirect, mem_access, perf_clr;
    logic [1:0] ex_wd_sel;
    // control vector: {pc, if_id, id_ex, ex_mem stalls, if_id, id_ex flushes, mem_wb flush, busy}
    wire  [7:0]  c2, c3, c4;
    wire  [31:0] sc2, fe2, sc4, fe4;
    wire  [3:0]  sc3, fe3;
    typedef struct {string tag; int sel; logic [31:0] v;} exp_t;
    exp_t q[$];
    int n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.MEM_LAT(2), .CNT_W(32)) d2 (
        .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used),
        .id_rs2_used(id_rs2_used), .ex_wR(ex_wR), .ex_rf_we(ex_rf_we), .ex_wd_sel(ex_wd_sel),
        .ex_redirect(ex_redirect), .mem_access(mem_access), .perf_clr(perf_clr),
        .pc_stall(c2[7]), .if_id_stall(c2[6]), .id_ex_stall(c2[5]), .ex_mem_stall(c2[4]),
        .if_id_flush(c2[3]), .id_ex_flush(c2[2]), .mem_wb_flush(c2[1]),
        .stall_cycles(sc2), .flush_events(fe2), .busy(c2[0]));
    pipe_hazard_ctrl #(.MEM_LAT(3), .CNT_W(4)) d3 (
        .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used),
        .id_rs2_used(id_rs2_used), .ex_wR(ex_wR), .ex_rf_we(ex_rf_we), .ex_wd_sel(ex_wd_sel),
        .ex_redirect(ex_redirect), .mem_access(mem_access), .perf_clr(perf_clr),
        .pc_stall(c3[7]), .if_id_stall(c3[6]), .id_ex_stall(c3[5]), .ex_mem_stall(c3[4]),
        .if_id_flush(c3[3]), .id_ex_flush(c3[2]), .mem_wb_flush(c3[1]),
        .stall_cycles(sc3), .flush_events(fe3), .busy(c3[0]));
    pipe_hazard_ctrl #(.MEM_LAT(4), .CNT_W(32)) d4 (
        .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used),
        .id_rs2_used(id_rs2_used), .ex_wR(ex_wR), .ex_rf_we(ex_rf_we), .ex_wd_sel(ex_wd_sel),
        .ex_redirect(ex_redirect), .mem_access(mem_access), .perf_clr(perf_clr),
        .pc_stall(c4[7]), .if_id_stall(c4[6]), .id_ex_stall(c4[5]), .ex_mem_stall(c4[4]),
        .if_id_flush(c4[3]), .id_ex_flush(c4[2]), .mem_wb_flush(c4[1]),
        .stall_cycles(sc4), .flush_events(fe4), .busy(c4[0]));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] obs(input int sel);
        case (sel)
            0: return {24'd0, c2};
            1: return {24'd0, c3};
            2: return {24'd0, c4};
            3: return sc2;
            4: return fe2;
            5: return {28'd0, sc3};
            6: return {28'd0, fe3};
            7: return sc4;
            default: return fe4;
        endcase
    endfunction

    task automatic push(input string tag, input int sel, input logic [31:0] v);
        q.push_back('{tag, sel, v});
    endtask

    task automatic drain;
        #1;
        while (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            check(e.tag, obs(e.sel), e.v);
        end
    endtask

    task automatic step;
        drain();
        @(negedge clk);
    endtask

    task automatic idle;
        id_rs1 = 0; id_rs2 = 0; ex_wR = 0; ex_wd_sel = 0;
        id_rs1_used = 0; id_rs2_used = 0; ex_rf_we = 0;
        ex_redirect = 0; mem_access = 0; perf_clr = 0;
    endtask

    task automatic do_reset;
        idle();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic load_use_r2;
        ex_rf_we = 1; ex_wd_sel = 2'b01; ex_wR = 5'd5; id_rs2 = 5'd5; id_rs2_used = 1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        idle();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        push("rst_ctl", 2, 0); push("rst_sc", 7, 0); push("rst_fe", 8, 0);
        step();
        // reset in the middle of a MEM_LAT=4 freeze
        do_reset();
        mem_access = 1;
        push("t1_trig", 2, 8'hF2);
        step();
        mem_access = 0;
        push("t1_wait", 2, 8'hF3);
        drain();
        rst_n = 1'b0; mem_access = 1; ex_redirect = 1; load_use_r2();
        push("t1_rst2", 0, 0); push("t1_rst3", 1, 0); push("t1_rst4", 2, 0);
        drain();
        @(negedge clk);
        idle();
        rst_n = 1'b1;
        push("t1_post", 2, 0); push("t1_post_sc", 7, 0); push("t1_post_fe", 8, 0);
        step();
        push("t1_post2", 2, 0);
        step();
        // MEM_LAT=3 single access, instruction held in MEM during the freeze
        do_reset();
        mem_access = 1;
        push("t2_T0", 1, 8'hF2);
        step();
        push("t2_T1", 1, 8'hF3);
        step();
        push("t2_done", 1, 8'h01);
        step();
        mem_access = 0;
        push("t2_run", 1, 0); push("t2_sc", 5, 2);
        step();
        // load-use detection and its qualifiers
        do_reset();
        load_use_r2();
        push("t3_lu_rs2", 1, 8'hC4);
        step();
        ex_wR = 0; id_rs2 = 0;
        push("t3_x0", 1, 0);
        step();
        ex_wR = 5; id_rs2 = 5; ex_wd_sel = 2'b00;
        push("t3_alu", 1, 0);
        step();
        ex_wd_sel = 2'b01; id_rs2_used = 0; id_rs1 = 5; id_rs1_used = 1;
        push("t3_lu_rs1", 1, 8'hC4);
        step();
        id_rs1_used = 0;
        push("t3_unused", 1, 0);
        step();
        idle();
        push("t3_sc", 5, 2);
        step();
        // redirect beats load-use
        do_reset();
        load_use_r2();
        ex_redirect = 1;
        push("t4_redir", 1, 8'h0C);
        step();
        idle();
        push("t4_fe", 6, 1); push("t4_sc", 5, 0); push("t4_idle", 1, 0);
        step();
        // MEM_LAT=2: access and redirect together, flush deferred to MEM_DONE
        do_reset();
        mem_access = 1; ex_redirect = 1;
        push("t5_freeze", 0, 8'hF2);
        step();
        push("t5_done", 0, 8'h0D);
        step();
        idle();
        push("t5_idle", 0, 0); push("t5_fe", 4, 1); push("t5_sc", 3, 1);
        step();
        // 4-bit counter saturation and clear priority
        do_reset();
        load_use_r2();
        for (int i = 0; i < 20; i++) begin
            push("t6_lu", 1, 8'hC4);
            step();
        end
        perf_clr = 1;
        push("t6_sat", 5, 15); push("t6_lu_clr", 1, 8'hC4);
        step();
        idle();
        push("t6_clr", 5, 0);
        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
